// File: rtl/hdcpu_pkg.sv
// Shared types and defaults for the HD-CPU vectored interrupt controller.
// Return-stack frames are sized for the widest supported PC; narrower PCs zero-extend.
package hdcpu_pkg;

  localparam int DEF_NCH        = 4;
  localparam int DEF_PCW        = 8;
  localparam int DEF_DEPTH      = 2;
  localparam int DEF_VEC_BASE   = 'hE0;
  localparam int DEF_VEC_STRIDE = 4;
  localparam int PCW_MAX        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEC  = 2'd1,
    RET  = 2'd2
  } intc_state_t;

  typedef struct packed {
    logic [PCW_MAX-1:0] pc;
    logic [2:0]         ch;
    logic               ie;
  } intc_frame_t;

  // Vector address for a channel before truncation to the PC width.
  function automatic logic [PCW_MAX-1:0] vec_addr(input int base, input int stride,
                                                  input logic [2:0] ch);
    return PCW_MAX'(base + stride * int'(ch));
  endfunction

endpackage

// File: rtl/hdcpu_intc_if.sv
// Controller <-> interrupt controller signal bundle.
// The controller side is the master; the interrupt controller is the slave.
interface hdcpu_intc_if import hdcpu_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int PCW = DEF_PCW
);
  logic [NCH-1:0] IRQ;
  logic           MASK_WE;
  logic [NCH-1:0] MASK_D;
  logic           EI_SET;
  logic           EI_CLR;
  logic           INT_ACK;
  logic [PCW-1:0] PC_IN;
  logic           IRET;

  logic           INT_REQ;
  logic           VEC_VALID;
  logic [PCW-1:0] VECTOR;
  logic [2:0]     INT_CH;
  logic           RET_VALID;
  logic [PCW-1:0] RET_PC;
  logic           IE;
  logic [2:0]     ACTIVE;
  logic           ERR;

  modport master (
    output IRQ, MASK_WE, MASK_D, EI_SET, EI_CLR, INT_ACK, PC_IN, IRET,
    input  INT_REQ, VEC_VALID, VECTOR, INT_CH, RET_VALID, RET_PC, IE, ACTIVE, ERR
  );

  modport slave (
    input  IRQ, MASK_WE, MASK_D, EI_SET, EI_CLR, INT_ACK, PC_IN, IRET,
    output INT_REQ, VEC_VALID, VECTOR, INT_CH, RET_VALID, RET_PC, IE, ACTIVE, ERR
  );

endinterface

// File: rtl/hdcpu_intc_prio.sv
// Lowest-index-wins priority encoder over up to 8 request lines; purely combinational.
module hdcpu_intc_prio #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [2:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/hdcpu_intc.sv
// Vectored, nestable interrupt controller with a hardware return stack of {PC, channel, IE}.
// All state advances on the falling edge of T3; CLR clears everything asynchronously.
module hdcpu_intc import hdcpu_pkg::*; #(
  parameter int             NCH        = DEF_NCH,
  parameter int             PCW        = DEF_PCW,
  parameter int             DEPTH      = DEF_DEPTH,
  parameter logic [PCW-1:0] VEC_BASE   = PCW'(DEF_VEC_BASE),
  parameter int             VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic       T3,
  input  logic       CLR,
  hdcpu_intc_if.slave bus
);

  logic [NCH-1:0] irq_q, pend_q, mask_q, pend_d;
  logic           ie_q, ie_d, err_q;
  intc_state_t    state_q;
  intc_frame_t    stack_q [DEPTH];
  logic [2:0]     active_q;
  logic [PCW-1:0] vector_q, ret_pc_q;
  logic [2:0]     int_ch_q;
  logic           vec_valid_q, ret_valid_q;

  logic           cand_found;
  logic [2:0]     cand_idx;
  intc_frame_t    top_frame;
  logic [3:0]     cur_ch;
  logic           idle, int_req, ack_ok, iret_ok, proto_err;

  hdcpu_intc_prio #(.N(NCH)) u_prio (
    .req   (pend_q & mask_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  always_comb begin
    top_frame = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (active_q == 3'(i + 1)) top_frame = stack_q[i];
    end
  end

  // With nothing in service every channel outranks the virtual channel NCH.
  assign cur_ch  = (active_q == 3'd0) ? 4'(NCH) : {1'b0, top_frame.ch};
  assign idle    = (state_q == IDLE);
  assign int_req = idle & ie_q & cand_found & ({1'b0, cand_idx} < cur_ch)
                 & (active_q < 3'(DEPTH));

  assign ack_ok    = idle & bus.INT_ACK & ~bus.IRET & int_req;
  assign iret_ok   = idle & bus.IRET & (active_q != 3'd0);
  assign proto_err = (~idle & (bus.INT_ACK | bus.IRET))
                   | (bus.INT_ACK & ~int_req)
                   | (bus.IRET & (active_q == 3'd0))
                   | (bus.INT_ACK & bus.IRET);

  // A fresh IRQ edge re-arms a channel even in the cycle it is acknowledged.
  always_comb begin
    pend_d = pend_q;
    if (ack_ok) pend_d = pend_d & ~(NCH'(1) << cand_idx);
    pend_d = pend_d | (bus.IRQ & ~irq_q);
  end

  always_comb begin
    ie_d = ie_q;
    if (ack_ok)          ie_d = 1'b0;
    else if (iret_ok)    ie_d = top_frame.ie;
    else if (bus.EI_CLR) ie_d = 1'b0;
    else if (bus.EI_SET) ie_d = 1'b1;
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      irq_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '1;
      ie_q        <= 1'b1;
      err_q       <= 1'b0;
      state_q     <= IDLE;
      active_q    <= 3'd0;
      vector_q    <= '0;
      int_ch_q    <= 3'd0;
      ret_pc_q    <= '0;
      vec_valid_q <= 1'b0;
      ret_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      irq_q       <= bus.IRQ;
      pend_q      <= pend_d;
      ie_q        <= ie_d;
      err_q       <= err_q | proto_err;
      vec_valid_q <= 1'b0;
      ret_valid_q <= 1'b0;
      if (bus.MASK_WE) mask_q <= bus.MASK_D;
      case (state_q)
        IDLE: begin
          if (iret_ok) begin
            active_q    <= active_q - 3'd1;
            ret_pc_q    <= PCW'(top_frame.pc);
            ret_valid_q <= 1'b1;
            state_q     <= RET;
          end else if (ack_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (active_q == 3'(i))
                stack_q[i] <= '{pc: PCW_MAX'(bus.PC_IN), ch: cand_idx, ie: ie_q};
            end
            active_q    <= active_q + 3'd1;
            vector_q    <= PCW'(vec_addr(int'(VEC_BASE), VEC_STRIDE, cand_idx));
            int_ch_q    <= cand_idx;
            vec_valid_q <= 1'b1;
            state_q     <= VEC;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.INT_REQ   = int_req;
  assign bus.VEC_VALID = vec_valid_q;
  assign bus.VECTOR    = vector_q;
  assign bus.INT_CH    = int_ch_q;
  assign bus.RET_VALID = ret_valid_q;
  assign bus.RET_PC    = ret_pc_q;
  assign bus.IE        = ie_q;
  assign bus.ACTIVE    = active_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_hdcpu_intc.sv
// Bench for hdcpu_intc: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based behavioural model of the controller.
module tb_hdcpu_intc;

  localparam int NCH   = 4;
  localparam int PCW   = 8;
  localparam int DEPTH = 2;

  logic T3  = 1'b0;
  logic CLR = 1'b1;
  always #5 T3 = ~T3;

  hdcpu_intc_if #(.NCH(NCH), .PCW(PCW)) bus ();

  hdcpu_intc #(
    .NCH(NCH), .PCW(PCW), .DEPTH(DEPTH), .VEC_BASE(8'hE0), .VEC_STRIDE(4)
  ) dut (
    .T3  (T3),
    .CLR (CLR),
    .bus (bus)
  );

  typedef struct {
    int pc;
    int ch;
    bit ie;
  } frame_t;

  frame_t         m_stack[$];
  bit [NCH-1:0]   m_pend, m_mask, m_irq;
  bit             m_ie, m_err, m_vp, m_rp;
  int             m_vector, m_ch, m_ret;
  int             n_vec = 0;
  int             n_bad = 0;
  bit             chk_en = 1'b0;

  function automatic int m_cand();
    for (int c = 0; c < NCH; c++) if (m_pend[c] && m_mask[c]) return c;
    return -1;
  endfunction

  function automatic bit m_req();
    int c;
    int cur;
    c   = m_cand();
    cur = (m_stack.size() == 0) ? NCH : m_stack[$].ch;
    return !m_vp && !m_rp && m_ie && (c >= 0) && (c < cur) && (m_stack.size() < DEPTH);
  endfunction

  task automatic m_reset();
    m_stack.delete();
    m_pend = '0; m_mask = '1; m_irq = '0;
    m_ie = 1'b1; m_err = 1'b0; m_vp = 1'b0; m_rp = 1'b0;
    m_vector = 0; m_ch = 0; m_ret = 0;
  endtask

  task automatic m_step();
    bit     idle, req, ack_ok, iret_ok;
    int     c;
    frame_t f;
    idle    = !m_vp && !m_rp;
    req     = m_req();
    c       = m_cand();
    ack_ok  = idle && bus.INT_ACK && !bus.IRET && req;
    iret_ok = idle && bus.IRET && (m_stack.size() > 0);
    if ((bus.INT_ACK || bus.IRET) && !idle) m_err = 1'b1;
    if (bus.INT_ACK && !req) m_err = 1'b1;
    if (bus.IRET && m_stack.size() == 0) m_err = 1'b1;
    if (bus.INT_ACK && bus.IRET) m_err = 1'b1;
    if (ack_ok) m_pend[c] = 1'b0;
    m_pend = m_pend | (bus.IRQ & ~m_irq);
    m_irq  = bus.IRQ;
    if (bus.MASK_WE) m_mask = bus.MASK_D;
    if (ack_ok) begin
      f.pc = int'(bus.PC_IN); f.ch = c; f.ie = m_ie;
      m_stack.push_back(f);
      m_ie = 1'b0;
      m_vector = (32'hE0 + c * 4) % 256;
      m_ch = c;
    end else if (iret_ok) begin
      f = m_stack.pop_back();
      m_ie = f.ie;
      m_ret = f.pc;
    end else if (bus.EI_CLR) m_ie = 1'b0;
    else if (bus.EI_SET) m_ie = 1'b1;
    m_vp = ack_ok;
    m_rp = iret_ok;
  endtask

  always @(negedge T3) if (CLR) m_step();

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge T3) begin
    if (chk_en) begin
      n_vec++;
      cmp("INT_REQ",   int'(bus.INT_REQ),   int'(m_req()));
      cmp("VEC_VALID", int'(bus.VEC_VALID), int'(m_vp));
      cmp("VECTOR",    int'(bus.VECTOR),    m_vector);
      cmp("INT_CH",    int'(bus.INT_CH),    m_ch);
      cmp("RET_VALID", int'(bus.RET_VALID), int'(m_rp));
      cmp("RET_PC",    int'(bus.RET_PC),    m_ret);
      cmp("IE",        int'(bus.IE),        int'(m_ie));
      cmp("ACTIVE",    int'(bus.ACTIVE),    m_stack.size());
      cmp("ERR",       int'(bus.ERR),       int'(m_err));
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    cmp(name, act, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge T3);
      #1;
    end
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    m_reset();
  endtask

  initial begin
    bus.IRQ = '0; bus.MASK_WE = 1'b0; bus.MASK_D = '0; bus.EI_SET = 1'b0;
    bus.EI_CLR = 1'b0; bus.INT_ACK = 1'b0; bus.PC_IN = '0; bus.IRET = 1'b0;
    #1;
    do_reset();
    chk_en = 1'b1;
    cyc(2);
    lit("rst_IE", int'(bus.IE), 1);
    lit("rst_INT_REQ", int'(bus.INT_REQ), 0);
    lit("rst_VEC_VALID", int'(bus.VEC_VALID), 0);
    lit("rst_RET_VALID", int'(bus.RET_VALID), 0);
    lit("rst_ACTIVE", int'(bus.ACTIVE), 0);
    lit("rst_ERR", int'(bus.ERR), 0);
    CLR = 1'b1;
    cyc();

    // Single request and return
    bus.IRQ = 4'b0100; cyc();
    lit("single_INT_REQ", int'(bus.INT_REQ), 1);
    bus.PC_IN = 8'h3A; bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("single_VEC_VALID", int'(bus.VEC_VALID), 1);
    lit("single_VECTOR", int'(bus.VECTOR), 'hE8);
    lit("single_INT_CH", int'(bus.INT_CH), 2);
    lit("single_IE", int'(bus.IE), 0);
    lit("single_ACTIVE", int'(bus.ACTIVE), 1);
    lit("single_INT_REQ_vec", int'(bus.INT_REQ), 0);
    cyc();
    bus.IRET = 1'b1; cyc(); bus.IRET = 1'b0;
    lit("single_RET_VALID", int'(bus.RET_VALID), 1);
    lit("single_RET_PC", int'(bus.RET_PC), 'h3A);
    lit("single_IE_ret", int'(bus.IE), 1);
    lit("single_ACTIVE_ret", int'(bus.ACTIVE), 0);
    cyc();

    // Priority and nesting
    bus.IRQ = 4'b1110; cyc();
    bus.PC_IN = 8'h20; bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("prio_INT_CH", int'(bus.INT_CH), 1);
    lit("prio_VECTOR", int'(bus.VECTOR), 'hE4);
    cyc();
    bus.EI_SET = 1'b1; cyc(); bus.EI_SET = 1'b0; cyc();
    lit("prio_IE", int'(bus.IE), 1);
    lit("prio_ch3_blocked", int'(bus.INT_REQ), 0);
    bus.IRQ = 4'b1111; cyc();
    lit("nest_INT_REQ", int'(bus.INT_REQ), 1);
    bus.PC_IN = 8'h50; bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("nest_INT_CH", int'(bus.INT_CH), 0);
    lit("nest_ACTIVE", int'(bus.ACTIVE), 2);
    lit("nest_VECTOR", int'(bus.VECTOR), 'hE0);
    cyc();
    bus.IRET = 1'b1; cyc(); bus.IRET = 1'b0;
    lit("nest_RET_PC1", int'(bus.RET_PC), 'h50);
    lit("nest_ACTIVE1", int'(bus.ACTIVE), 1);
    cyc();
    bus.IRET = 1'b1; cyc(); bus.IRET = 1'b0;
    lit("nest_RET_PC2", int'(bus.RET_PC), 'h20);
    lit("nest_ACTIVE2", int'(bus.ACTIVE), 0);
    cyc();

    // Depth limit: ch3 then ch2 stacked, ch1 pending must wait
    bus.PC_IN = 8'h11; bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("depth_INT_CH3", int'(bus.INT_CH), 3);
    cyc();
    bus.EI_SET = 1'b1; bus.IRQ = 4'b0000; cyc();
    bus.EI_SET = 1'b0; bus.IRQ = 4'b0100; cyc(2);
    lit("depth_INT_REQ_ch2", int'(bus.INT_REQ), 1);
    bus.PC_IN = 8'h12; bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("depth_INT_CH2", int'(bus.INT_CH), 2);
    lit("depth_ACTIVE", int'(bus.ACTIVE), 2);
    cyc();
    bus.EI_SET = 1'b1; bus.IRQ = 4'b0110; cyc(); bus.EI_SET = 1'b0; cyc();
    lit("depth_IE", int'(bus.IE), 1);
    lit("depth_full_INT_REQ", int'(bus.INT_REQ), 0);
    bus.IRET = 1'b1; cyc(); bus.IRET = 1'b0;
    lit("depth_RET_PC", int'(bus.RET_PC), 'h12);
    cyc();
    lit("depth_after_INT_REQ", int'(bus.INT_REQ), 1);

    // Mask and global enable
    bus.IRQ = '0; do_reset(); cyc(); CLR = 1'b1;
    bus.MASK_D = 4'hB; bus.MASK_WE = 1'b1; cyc(); bus.MASK_WE = 1'b0;
    bus.IRQ = 4'b0100; cyc(2);
    lit("mask_INT_REQ_off", int'(bus.INT_REQ), 0);
    bus.MASK_D = 4'hF; bus.MASK_WE = 1'b1; cyc(); bus.MASK_WE = 1'b0;
    lit("mask_INT_REQ_on", int'(bus.INT_REQ), 1);
    bus.EI_SET = 1'b1; bus.EI_CLR = 1'b1; cyc(); bus.EI_SET = 1'b0; bus.EI_CLR = 1'b0;
    lit("eidi_IE", int'(bus.IE), 0);
    lit("eidi_INT_REQ", int'(bus.INT_REQ), 0);

    // Protocol errors
    bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("err_ack_ERR", int'(bus.ERR), 1);
    lit("err_ack_VEC_VALID", int'(bus.VEC_VALID), 0);
    do_reset(); cyc(); CLR = 1'b1;
    lit("err_clr_ERR", int'(bus.ERR), 0);
    bus.IRET = 1'b1; cyc(); bus.IRET = 1'b0;
    lit("err_iret_ERR", int'(bus.ERR), 1);
    lit("err_iret_RET_VALID", int'(bus.RET_VALID), 0);
    bus.IRQ = '0; do_reset(); cyc(); CLR = 1'b1;
    bus.IRQ = 4'b0001; cyc();
    lit("err_both_INT_REQ", int'(bus.INT_REQ), 1);
    bus.INT_ACK = 1'b1; bus.IRET = 1'b1; cyc(); bus.INT_ACK = 1'b0; bus.IRET = 1'b0;
    lit("err_both_ERR", int'(bus.ERR), 1);
    lit("err_both_VEC_VALID", int'(bus.VEC_VALID), 0);
    lit("err_both_ACTIVE", int'(bus.ACTIVE), 0);
    cyc(3);
    lit("err_sticky", int'(bus.ERR), 1);

    // Reset during VEC
    bus.INT_ACK = 1'b1; cyc(); bus.INT_ACK = 1'b0;
    lit("midvec_VEC_VALID_pre", int'(bus.VEC_VALID), 1);
    bus.IRQ = '0; do_reset(); #1;
    lit("midvec_VEC_VALID", int'(bus.VEC_VALID), 0);
    lit("midvec_ACTIVE", int'(bus.ACTIVE), 0);
    lit("midvec_ERR", int'(bus.ERR), 0);
    cyc(); CLR = 1'b1; cyc(3);
    lit("midvec_INT_REQ", int'(bus.INT_REQ), 0);
    lit("midvec_no_pulse", int'(bus.VEC_VALID), 0);

    // Random traffic against the model
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, NCH - 1);
        bus.IRQ[b] = ~bus.IRQ[b];
      end
      bus.MASK_WE = ($urandom_range(0, 15) == 0);
      bus.MASK_D  = NCH'($urandom);
      bus.EI_SET  = ($urandom_range(0, 9) == 0);
      bus.EI_CLR  = ($urandom_range(0, 19) == 0);
      bus.PC_IN   = PCW'($urandom);
      bus.INT_ACK = m_req() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      bus.IRET    = (m_stack.size() > 0) ? ($urandom_range(0, 5) == 0)
                                          : ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else CLR = 1'b1;
      cyc();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
